// File: rtl/resize_accel_udiv_22ns_16ns_seq.sv
// Sequential restoring unsigned divider: one quotient bit per enabled cycle, valid/ready handshakes.
// Optional divide-by-zero flag output enabled by defining RESIZE_ACCEL_UDIV_DBZ_FLAG_EN.
module resize_accel_udiv_22ns_16ns_seq #(
    parameter int DIVIDEND_WIDTH = 22,
    parameter int DIVISOR_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [DIVIDEND_WIDTH-1:0] quot,
    output logic [DIVISOR_WIDTH-1:0]  rem
`ifdef RESIZE_ACCEL_UDIV_DBZ_FLAG_EN
    ,
    output logic                      dbz
`endif
);
    localparam int QW = DIVIDEND_WIDTH;
    localparam int DW = DIVISOR_WIDTH;
    localparam int CW = $clog2(DIVIDEND_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [QW-1:0] dvd_q;      // dividend bits shift out MSB first, quotient bits shift in
    logic [DW-1:0] dsr_q;
    logic [DW-1:0] r_q;
    logic [QW-1:0] quot_q;
    logic [DW-1:0] rem_q;
    logic          in_rdy_q;
    logic          out_vld_q;
`ifdef RESIZE_ACCEL_UDIV_DBZ_FLAG_EN
    logic          dbz_q;
`endif

    logic [DW:0]   tmp;
    logic          ge;
    logic [DW-1:0] r_d;
    logic [QW-1:0] dvd_d;

    // The working remainder is DW+1 bits; when its top bit is set it already
    // exceeds any divisor and the true difference fits in DW bits.
    always_comb begin
        tmp   = {r_q, dvd_q[QW-1]};
        ge    = tmp[DW] | (tmp[DW-1:0] >= dsr_q);
        r_d   = ge ? (tmp[DW-1:0] - dsr_q) : tmp[DW-1:0];
        dvd_d = {dvd_q[QW-2:0], ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            r_q       <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
`ifdef RESIZE_ACCEL_UDIV_DBZ_FLAG_EN
            dbz_q     <= 1'b0;
`endif
        end else if (ce) begin
            case (state_q)
                IDLE: begin
                    if (in_vld) begin
                        dvd_q    <= din0;
                        dsr_q    <= din1;
                        r_q      <= '0;
                        cnt_q    <= '0;
                        in_rdy_q <= 1'b0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != CW'(QW)) begin
                        dvd_q <= dvd_d;
                        r_q   <= r_d;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        // Extra cycle registers the result, giving QW+1 cycles total.
                        quot_q    <= dvd_q;
                        rem_q     <= r_q;
                        out_vld_q <= 1'b1;
`ifdef RESIZE_ACCEL_UDIV_DBZ_FLAG_EN
                        dbz_q     <= (dsr_q == '0);
`endif
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
`ifdef RESIZE_ACCEL_UDIV_DBZ_FLAG_EN
                        dbz_q     <= 1'b0;
`endif
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    in_rdy_q  <= 1'b1;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_vld = out_vld_q;
    assign quot    = quot_q;
    assign rem     = rem_q;
`ifdef RESIZE_ACCEL_UDIV_DBZ_FLAG_EN
    assign dbz     = dbz_q;
`endif

endmodule

// File: tb/tb_resize_accel_udiv_22ns_16ns_seq.sv
// Directed bench for the sequential divider: latency, results, ce stalls, backpressure, reset abort.
module tb_resize_accel_udiv_22ns_16ns_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_vld;
    logic        in_rdy;
    logic [21:0] din0;
    logic [15:0] din1;
    logic        out_vld;
    logic        out_rdy;
    logic [21:0] quot;
    logic [15:0] rem;
`ifdef RESIZE_ACCEL_UDIV_DBZ_FLAG_EN
    logic        dbz;
`endif

    int tests = 0;
    int fails = 0;

    resize_accel_udiv_22ns_16ns_seq dut (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .in_rdy(in_rdy),
        .din0(din0), .din1(din1), .out_vld(out_vld), .out_rdy(out_rdy),
        .quot(quot), .rem(rem)
`ifdef RESIZE_ACCEL_UDIV_DBZ_FLAG_EN
        , .dbz(dbz)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Accept one operation, optionally stall ce for gap_len cycles starting gap_at
    // cycles after accept; returns number of edges from accept to out_vld.
    task automatic run_op(input logic [21:0] a, input logic [15:0] b,
                          input int gap_at, input int gap_len, output int lat);
        int n;
        @(negedge clk);
        din0 = a; din1 = b; in_vld = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        chk("busy_in_rdy", {31'd0, in_rdy}, 32'd0);
        in_vld = 1'b0;
        n = 0;
        while (out_vld !== 1'b1 && n < 200) begin
            @(negedge clk);
            ce     = !(n >= gap_at && n < gap_at + gap_len);
            in_vld = (n == 3);
            din0   = 22'($urandom);
            din1   = 16'($urandom);
            @(posedge clk); #1;
            n++;
        end
        ce = 1'b1; in_vld = 1'b0;
        lat = n;
    endtask

    task automatic consume;
        @(negedge clk);
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        chk("drain_out_vld", {31'd0, out_vld}, 32'd0);
        chk("drain_in_rdy", {31'd0, in_rdy}, 32'd1);
    endtask

    initial begin
        int lat;
        reset = 1'b1; ce = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; din0 = '0; din1 = '0;
        #12;
        chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_quot", {10'd0, quot}, 32'd0);
        chk("rst_rem", {16'd0, rem}, 32'd0);
        @(negedge clk); reset = 1'b0; ce = 1'b1;

        run_op(22'd1000000, 16'd640, 1000, 0, lat);
        chk("basic_lat", lat, 32'd23);
        chk("basic_quot", {10'd0, quot}, 32'd1562);
        chk("basic_rem", {16'd0, rem}, 32'd320);
        consume();

        run_op(22'd4194303, 16'd1, 1000, 0, lat);
        chk("div1_quot", {10'd0, quot}, 32'd4194303);
        chk("div1_rem", {16'd0, rem}, 32'd0);
        consume();

        run_op(22'd5, 16'd7, 1000, 0, lat);
        chk("small_quot", {10'd0, quot}, 32'd0);
        chk("small_rem", {16'd0, rem}, 32'd5);
        consume();

        run_op(22'd4194303, 16'd65535, 1000, 0, lat);
        chk("maxdiv_quot", {10'd0, quot}, 32'd64);
        chk("maxdiv_rem", {16'd0, rem}, 32'd63);
        consume();

        run_op(22'd12345, 16'd0, 1000, 0, lat);
        chk("dbz_lat", lat, 32'd23);
        chk("dbz_quot", {10'd0, quot}, 32'h3FFFFF);
        chk("dbz_rem", {16'd0, rem}, 32'd12345);
`ifdef RESIZE_ACCEL_UDIV_DBZ_FLAG_EN
        chk("dbz_flag", {31'd0, dbz}, 32'd1);
`endif
        consume();
`ifdef RESIZE_ACCEL_UDIV_DBZ_FLAG_EN
        chk("dbz_cleared", {31'd0, dbz}, 32'd0);
`endif

        // ce stall mid-BUSY, then backpressure and ce-low hold in DONE
        run_op(22'd1000000, 16'd640, 5, 10, lat);
        chk("stall_lat", lat, 32'd33);
        chk("stall_quot", {10'd0, quot}, 32'd1562);
        chk("stall_rem", {16'd0, rem}, 32'd320);
`ifdef RESIZE_ACCEL_UDIV_DBZ_FLAG_EN
        chk("stall_dbz", {31'd0, dbz}, 32'd0);
`endif
        repeat (5) @(posedge clk);
        #1;
        chk("hold_out_vld", {31'd0, out_vld}, 32'd1);
        chk("hold_in_rdy", {31'd0, in_rdy}, 32'd0);
        chk("hold_quot", {10'd0, quot}, 32'd1562);
        chk("hold_rem", {16'd0, rem}, 32'd320);
        @(negedge clk); ce = 1'b0; out_rdy = 1'b1;
        @(posedge clk); #1;
        chk("ce_low_out_vld", {31'd0, out_vld}, 32'd1);
        chk("ce_low_quot", {10'd0, quot}, 32'd1562);
        ce = 1'b1; out_rdy = 1'b0;
        consume();

        // reset abort at iteration 10
        @(negedge clk);
        din0 = 22'd1000000; din1 = 16'd640; in_vld = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        chk("abort_out_vld", {31'd0, out_vld}, 32'd0);
        chk("abort_in_rdy", {31'd0, in_rdy}, 32'd1);
        chk("abort_quot", {10'd0, quot}, 32'd0);
        @(negedge clk); reset = 1'b0;
        run_op(22'd300, 16'd7, 1000, 0, lat);
        chk("post_rst_lat", lat, 32'd23);
        chk("post_rst_quot", {10'd0, quot}, 32'd42);
        chk("post_rst_rem", {16'd0, rem}, 32'd6);
        consume();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
